clkduty: RTL and testbench
==========================

CLKDUTY -- requirements
Module: clkduty

Interface
REQ-001 Parameter DEB_CYCLES, default 4, number of consecutive stable clkin cycles a button level must hold before it is accepted (used only when CLKDUTY_DEBOUNCE_EN is defined).
REQ-002 clkin  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inc0  input  1  active-low button: duty +1 percent.
REQ-005 inc1  input  1  active-low button: duty +10 percent.
REQ-006 dec0  input  1  active-low button: duty -1 percent.
REQ-007 dec1  input  1  active-low button: duty -10 percent.
REQ-008 clk  output  1  PWM output, period 100 clkin cycles, high time = duty cycles.
REQ-009 clk2  output  1  complement of clk (clk2 = ~clk at all times).
REQ-010 d  output  8  current duty value in percent, unsigned binary, range 0..100.
REQ-011 d0  output  [0:6]  seven-segment pattern, units digit of d.
REQ-012 d1  output  [0:6]  seven-segment pattern, tens digit of d.
REQ-013 d2  output  [0:6]  seven-segment pattern, hundreds digit of d.
REQ-014 d3  output  [0:6]  seven-segment pattern, fixed blank.
REQ-015 Port order: clkin, inc0, inc1, dec0, dec1, reset, clk, clk2, d, d0, d1, d2, d3.

Function
REQ-016 Button press = falling edge of the (accepted) button level: registered previous level 1, current level 0; exactly one action per press regardless of hold time.
REQ-017 inc1: d = min(d+10, 100); inc0: d = min(d+1, 100); dec1: d = max(d-10, 0); dec0: d = max(d-1, 0); saturating, never wrapping.
REQ-018 Simultaneous presses in one cycle: only the highest priority acts, priority inc1 > inc0 > dec1 > dec0; others are discarded.
REQ-019 d updates on the clkin edge after the press is detected (one-cycle latency from detection).
REQ-020 Period counter cnt counts 0..99 and wraps to 0; increments every clkin cycle.
REQ-021 clk = 1 when cnt < d, else 0; d=0 gives constant 0, d=100 gives constant 1.
REQ-022 A duty change applies from the next comparison; the counter is not restarted.
REQ-023 Segment bits [0:6] = a..g, active-low (0 = lit); digits 0..9 standard: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; blank=1111111.
REQ-024 Leading-zero blanking: d2 blank unless d=100; d1 blank when d<10; d0 always shows a digit; d3 always blank.
REQ-025 Displays are combinational from d.

Reset
REQ-026 On reset high at a clkin edge: d=50, cnt=0, button history registers=1 (released), debounce counters=0; hence clk=1, clk2=0, d0 "0", d1 "5", d2 blank.
REQ-027 Reset mid-period or mid-press discards the pending press; reset has priority over button actions.

Configuration
REQ-028 Macro CLKDUTY_DEBOUNCE_EN: defined -> each button passes through a 2-flop synchronizer then a debouncer accepting a new level only after DEB_CYCLES consecutive equal samples; undefined -> each button passes through the 2-flop synchronizer only, and any low pulse spanning a clkin rising edge counts as a press.

Verification
REQ-029 Reset, buttons idle -> d=50, clk high for cnt 0..49 and low for 50..99, d1=0100100, d0=0000001, d2=d3=1111111.
REQ-030 From d=50 press inc1 twice, inc0 twice -> d=72; clk high 72 of every 100 cycles; clk2 = ~clk.
REQ-031 From d=95 press inc1 -> d=100, clk constant 1, d2=1001111; further inc0 -> d stays 100.
REQ-032 From d=5 press dec1 -> d=0, clk constant 0, d1 blank, d0=0000001; dec0 -> d stays 0.
REQ-033 inc1 and dec0 pressed same cycle from d=50 -> d=60 only; holding inc0 low 500 cycles -> d increases by exactly 1.
REQ-034 Reset asserted mid-period with d=72 -> next cycle d=50, cnt=0, clk=1; with CLKDUTY_DEBOUNCE_EN, a low pulse shorter than DEB_CYCLES cycles -> no change.

Source files
------------

// File: rtl/clkduty.sv
// clkduty: button-controlled PWM (period 100) with 7-seg duty readout.
// Optional debouncer enabled by defining CLKDUTY_DEBOUNCE_EN.
module clkduty #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clkin,
  input  logic       inc0,
  input  logic       inc1,
  input  logic       dec0,
  input  logic       dec1,
  input  logic       reset,
  output logic       clk,
  output logic       clk2,
  output logic [7:0] d,
  output logic [0:6] d0,
  output logic [0:6] d1,
  output logic [0:6] d2,
  output logic [0:6] d3
);

  localparam logic [0:6] BLANK = 7'b1111111;

  // bit 3 = inc1, 2 = inc0, 1 = dec1, 0 = dec0 (priority order)
  logic [3:0] btn_raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] lvl;
  logic [3:0] prev_q;
  logic [3:0] press;
  logic [7:0] duty_q;
  logic [7:0] duty_d;
  logic [6:0] cnt_q;
  logic [6:0] cnt_d;

  assign btn_raw = {inc1, inc0, dec1, dec0};

  // two-flop synchronizer, idle level is released (1)
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef CLKDUTY_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [3:0] deb_q;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] dcnt_q;
    // accept a new level after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clkin) begin
      if (reset) begin
        deb_q[i] <= 1'b1;
        dcnt_q   <= '0;
      end else if (sync2_q[i] == deb_q[i]) begin
        dcnt_q   <= '0;
      end else if (dcnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q[i] <= sync2_q[i];
        dcnt_q   <= '0;
      end else begin
        dcnt_q   <= dcnt_q + 1'b1;
      end
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  // level history for falling-edge press detection
  always_ff @(posedge clkin) begin
    if (reset) prev_q <= '1;
    else       prev_q <= lvl;
  end

  assign press = prev_q & ~lvl;

  // saturating duty update, highest-priority press wins
  always_comb begin
    duty_d = duty_q;
    priority case (1'b1)
      press[3]: duty_d = (duty_q >= 8'd90) ? 8'd100 : duty_q + 8'd10;
      press[2]: duty_d = (duty_q >= 8'd100) ? 8'd100 : duty_q + 8'd1;
      press[1]: duty_d = (duty_q <= 8'd10) ? 8'd0 : duty_q - 8'd10;
      press[0]: duty_d = (duty_q == 8'd0) ? 8'd0 : duty_q - 8'd1;
      default:  duty_d = duty_q;
    endcase
  end

  // period counter wraps 99 -> 0
  always_comb begin
    cnt_d = (cnt_q == 7'd99) ? 7'd0 : cnt_q + 7'd1;
  end

  // duty and counter state
  always_ff @(posedge clkin) begin
    if (reset) begin
      duty_q <= 8'd50;
      cnt_q  <= 7'd0;
    end else begin
      duty_q <= duty_d;
      cnt_q  <= cnt_d;
    end
  end

  assign d    = duty_q;
  assign clk  = ({1'b0, cnt_q} < duty_q);
  assign clk2 = ~clk;

  function automatic logic [0:6] seg(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic       hund;
  logic [3:0] tens;
  logic [3:0] units;

  // decimal split of duty (0..100) with leading-zero blanking
  always_comb begin
    hund = (duty_q >= 8'd100);
    tens = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (duty_q >= 8'(10 * k)) tens = 4'(k);
    end
    if (hund) tens = 4'd0;
    units = 4'(duty_q - 8'(tens * 4'd10));
    if (hund) units = 4'd0;
    d0 = seg(units);
    d1 = (duty_q < 8'd10) ? BLANK : seg(tens);
    d2 = hund ? seg(4'd1) : BLANK;
    d3 = BLANK;
  end

endmodule

// File: tb/tb_clkduty.sv
// tb_clkduty: table-driven and random checks of clkduty
// against a reference model of duty, period and display.
module tb_clkduty;

  localparam int DEB = 4;
`ifdef CLKDUTY_DEBOUNCE_EN
  localparam int HOLD_MIN = DEB + 2;
`else
  localparam int HOLD_MIN = 1;
`endif
  localparam int SETTLE = 12 + DEB;

  logic       clkin = 1'b0;
  logic       inc0 = 1'b1;
  logic       inc1 = 1'b1;
  logic       dec0 = 1'b1;
  logic       dec1 = 1'b1;
  logic       reset = 1'b1;
  logic       clk;
  logic       clk2;
  logic [7:0] d;
  logic [0:6] d0;
  logic [0:6] d1;
  logic [0:6] d2;
  logic [0:6] d3;

  clkduty #(.DEB_CYCLES(DEB)) dut (
    .clkin(clkin),
    .inc0(inc0),
    .inc1(inc1),
    .dec0(dec0),
    .dec1(dec1),
    .reset(reset),
    .clk(clk),
    .clk2(clk2),
    .d(d),
    .d0(d0),
    .d1(d1),
    .d2(d2),
    .d3(d3)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int md = 50;

  // cycles since the last reset edge; expected counter is cyc % 100
  always @(posedge clkin) cyc <= reset ? 0 : cyc + 1;

  // mask bits: 0 inc0, 1 inc1, 2 dec0, 3 dec1 (1 = pressed)
  typedef struct {
    logic [3:0] m;
    int         exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [0:6] seg(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int model(input int cur, input logic [3:0] m);
    if (m[1]) return (cur + 10 > 100) ? 100 : cur + 10;
    if (m[0]) return (cur + 1 > 100) ? 100 : cur + 1;
    if (m[3]) return (cur - 10 < 0) ? 0 : cur - 10;
    if (m[2]) return (cur - 1 < 0) ? 0 : cur - 1;
    return cur;
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] m);
    inc0 = ~m[0];
    inc1 = ~m[1];
    dec0 = ~m[2];
    dec1 = ~m[3];
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    set_btn(m);
    repeat (hold) tick();
    set_btn(4'b0000);
    repeat (SETTLE) tick();
    md = model(md, m);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    md = 50;
  endtask

  task automatic check_disp(input string tag);
    logic [0:6] e1;
    logic [0:6] e2;
    e1 = (md < 10) ? seg(-1) : seg((md / 10) % 10);
    e2 = (md == 100) ? seg(1) : seg(-1);
    chk({tag, "_d"}, int'(d), md);
    chk({tag, "_d0"}, int'(d0), int'(seg(md % 10)));
    chk({tag, "_d1"}, int'(d1), int'(e1));
    chk({tag, "_d2"}, int'(d2), int'(e2));
    chk({tag, "_d3"}, int'(d3), int'(seg(-1)));
  endtask

  task automatic check_period(input string tag);
    int bad;
    int highs;
    bad = 0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (clk !== ((cyc % 100) < md)) bad++;
      if (clk2 !== ~clk) bad++;
      if (clk === 1'b1) highs++;
    end
    chk({tag, "_clk_bad"}, bad, 0);
    chk({tag, "_highs"}, highs, md);
  endtask

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{4'b0010, 60};
    tbl[1]  = '{4'b0010, 70};
    tbl[2]  = '{4'b0001, 71};
    tbl[3]  = '{4'b0001, 72};
    tbl[4]  = '{4'b1000, 62};
    tbl[5]  = '{4'b0100, 61};
    tbl[6]  = '{4'b0110, 71};
    tbl[7]  = '{4'b1001, 72};
    tbl[8]  = '{4'b1100, 62};
    tbl[9]  = '{4'b1111, 72};
    tbl[10] = '{4'b0010, 82};
    tbl[11] = '{4'b0010, 92};
    tbl[12] = '{4'b0001, 93};
    tbl[13] = '{4'b0001, 94};
    tbl[14] = '{4'b0001, 95};
    tbl[15] = '{4'b0010, 100};
    tbl[16] = '{4'b0001, 100};
    tbl[17] = '{4'b0010, 100};
    tbl[18] = '{4'b0100, 99};
    tbl[19] = '{4'b1000, 89};
    tbl[20] = '{4'b0101, 90};

    repeat (2) tick();
    do_reset();
    chk("rst_clk", int'(clk), 1);
    chk("rst_clk2", int'(clk2), 0);
    check_disp("rst");
    check_period("rst");

    for (int i = 0; i < 21; i++) begin
      press(tbl[i].m, HOLD_MIN);
      md = tbl[i].exp;
      chk($sformatf("tbl%0d_d", i), int'(d), tbl[i].exp);
      check_disp($sformatf("tbl%0d", i));
      if (i == 3 || i == 15) check_period($sformatf("tbl%0d", i));
    end

    do_reset();
    repeat (4) press(4'b1000, HOLD_MIN);
    repeat (5) press(4'b0100, HOLD_MIN);
    chk("lo_d5", int'(d), 5);
    press(4'b1000, HOLD_MIN);
    check_disp("lo_zero");
    check_period("lo_zero");
    press(4'b0100, HOLD_MIN);
    chk("lo_sat", int'(d), 0);

    do_reset();
    press(4'b0110, HOLD_MIN);
    chk("prio_d", int'(d), 60);
    press(4'b0001, 500);
    chk("hold500_d", int'(d), 61);

    do_reset();
    press(4'b0010, HOLD_MIN);
    press(4'b0010, HOLD_MIN);
    press(4'b0001, HOLD_MIN);
    press(4'b0001, HOLD_MIN);
    chk("pre_rst_d", int'(d), 72);
    repeat (37) tick();
    do_reset();
    chk("midrst_d", int'(d), 50);
    chk("midrst_clk", int'(clk), 1);
    check_period("midrst");

    set_btn(4'b0010);
    tick();
    reset = 1'b1;
    set_btn(4'b0000);
    tick();
    reset = 1'b0;
    repeat (SETTLE) tick();
    chk("press_rst_d", int'(d), 50);

`ifdef CLKDUTY_DEBOUNCE_EN
    set_btn(4'b0010);
    repeat (DEB - 2) tick();
    set_btn(4'b0000);
    repeat (SETTLE) tick();
    chk("deb_short_d", int'(d), 50);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [3:0] m;
      int hold;
      m = 4'($urandom_range(0, 15));
      hold = HOLD_MIN + int'($urandom_range(0, 4));
      press(m, hold);
      check_disp($sformatf("rnd%0d", i));
      if (i % 15 == 14) check_period($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
